riscv_32i: RTL and testbench
============================

RISCV_32I -- requirements
Module: riscv_32i

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock for PC, register file and store timing.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port pc, output, 32: byte address of the current instruction.
REQ-005 SHALL have port instr, input, 32: instruction word at pc, combinational from memory.
REQ-006 SHALL have port memwrite, output, 1: data-word write enable, sampled by memory on posedge clk.
REQ-007 SHALL have port aluout, output, 32: ALU result, also the data byte address.
REQ-008 SHALL have port writedata, output, 32: full word written at aluout[31:2] when memwrite=1.
REQ-009 SHALL have port readdata, input, 32: combinational word at aluout[31:2].
REQ-010 SHALL have port dbg, output, mem_debug, present only under DBG_EN: per-instruction trace.

Function
REQ-011 SHALL be single-cycle: each clk edge retires exactly one instruction, with no stalls.
REQ-012 SHALL implement RV32I base integer ISA: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, all loads and stores, OP-IMM and OP with all ALU functions.
REQ-013 SHALL treat FENCE, ECALL, EBREAK and all undefined opcodes as NOP: pc+4, no register write, memwrite=0.
REQ-014 SHALL compute next PC as follows:
- pc+4 by default;
- pc+imm for JAL and for taken branches;
- (rs1+imm) with bit0 cleared for JALR.
REQ-015 SHALL write pc+4 to rd for JAL and JALR.
REQ-016 SHALL NOT check instruction address alignment and SHALL NOT trap on it.
REQ-017 SHALL sign-extend all immediates from instr[31]; LUI SHALL load {imm[31:12],12'b0}.
REQ-018 SHALL use 5-bit shift amounts: rs2[4:0] or shamt, with SRA/SRAI arithmetic.
REQ-019 SHALL compute SLT/SLTI signed and SLTU/SLTIU unsigned.
REQ-020 SHALL perform all arithmetic modulo 2^32, with overflow ignored.
REQ-021 SHALL select the load byte/half from readdata using aluout[1:0], then sign- or zero-extend per funct3.
REQ-022 SHALL perform stores as follows:
- SW drives rs2 as writedata;
- SB/SH drive writedata = readdata with the addressed byte/half replaced by rs2[7:0]/rs2[15:0];
- this single-cycle read-merge is valid because memory is word-wide with combinational read.
REQ-023 SHALL use natural half lanes for SH at aluout[1]; SW/SH misalignment SHALL be ignored (low address bits dropped, no trap).
REQ-024 SHALL assert memwrite only in store cycles.
REQ-025 SHALL have register file:
- 32x32, two combinational read ports, one write port on posedge clk;
- x0 reads 0 and writes to x0 are discarded;
- a read of a register written this cycle returns the old value.

Reset
REQ-026 SHALL on posedge clk with reset=1 load pc=RESET_PC and clear all registers x1..x31 to 0.
REQ-027 SHALL force memwrite=0 and suppress register writes while reset=1.
REQ-028 SHALL abandon the in-flight instruction when reset is asserted mid-program, and SHALL NOT commit any state from it.
REQ-029 SHALL fetch from RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL define the macro DBG_EN as follows:
- defined: port dbg exists and is driven combinationally each cycle with {pc, instr, regwrite, rd, rd write data, memwrite, aluout, writedata};
- undefined: port dbg and its logic are absent, and core behaviour is otherwise identical.

Structure
REQ-031 SHALL take from shared package dbg_pkg:
- struct typedef mem_debug;
- opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
- ALU-control enum.
REQ-032 SHALL contain one sub-module, regfile (2R1W, x0 hardwired), with decode, ALU, immediate generation and PC logic in riscv_32i.

Verification
REQ-033 SHALL cover ADDI and ADD: reset, then `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2` -> x3=2, pc=12 after 3 cycles.
REQ-034 SHALL cover store then load: `lui x1,0x12345; addi x1,x1,0x678; sw x1,64(x0); lw x2,64(x0)` -> memwrite=1 only in the sw cycle with aluout=64, writedata=0x12345678; x2=0x12345678.
REQ-035 SHALL cover byte ops: word 0x12345678 at addr 64, `sb x5(=0xAB),65(x0); lb x6,65(x0); lbu x7,65(x0)` -> memory word 0x1234AB78, x6=0xFFFFFFAB, x7=0x000000AB.
REQ-036 SHALL cover branches and jumps:
- `bne x0,x0,+8` -> pc+4;
- `blt x1(=-1),x0,+8` -> pc+8;
- `bltu` with the same operands -> not taken;
- `jal x1,+16` at pc=0x20 -> pc=0x30, x1=0x24;
- `jalr x0,3(x1)` with x1=0x24 -> pc=0x26.
REQ-037 SHALL cover x0 and reset:
- `addi x0,x0,7` -> x0 reads 0;
- reset asserted during a store cycle -> no memory write, pc=RESET_PC next cycle.
REQ-038 SHALL cover shifts and compares: x1=0x80000000 -> `srai x2,x1,4`=0xF8000000, `srli`=0x08000000, `slt x3,x1,x0`=1, `sltu x4,x1,x0`=0.

Source files
------------

// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg -- shared definitions for the riscv_32i single-cycle core.
//
// Contents:
//   mem_debug    : per-instruction trace record driven on the optional dbg port
//                  of riscv_32i (present only when the DBG_EN macro is defined)
//   opcode consts: RV32I major opcodes used by the decoder
//   alu_ctrl_e   : ALU operation select
//   alu_a_sel_e  : ALU A-operand source
//   wb_sel_e     : register write-back source
//   alu_decode() : funct3 (+ alternate bit) to ALU operation mapping
// -----------------------------------------------------------------------------
package dbg_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        regwrite;
      logic [4:0]  rd;
      logic [31:0] rd_wdata;
      logic        memwrite;
      logic [31:0] aluout;
      logic [31:0] writedata;
   } mem_debug;

   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      A_RS1,
      A_PC,
      A_ZERO
   } alu_a_sel_e;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_MEM,
      WB_PC4
   } wb_sel_e;

   // 'alt' is instr[30]; it only matters for funct3 0 (SUB) and 5 (SRA).
   // Callers must not set it for OP-IMM funct3 0, where ADDI has no SUB form.
   function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic alt);
      alu_ctrl_e r;
      case (f3)
         3'd0:    r = alt ? ALU_SUB : ALU_ADD;
         3'd1:    r = ALU_SLL;
         3'd2:    r = ALU_SLT;
         3'd3:    r = ALU_SLTU;
         3'd4:    r = ALU_XOR;
         3'd5:    r = alt ? ALU_SRA : ALU_SRL;
         3'd6:    r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/riscv_32i_regfile.sv
// -----------------------------------------------------------------------------
// regfile -- 32 x 32-bit integer register file, two combinational read ports,
// one write port on the rising clock edge. x0 always reads zero and writes to
// it are dropped. A read of a register written in the same cycle returns the
// old value (the write only lands at the clock edge).
//
// Ports:
//   clk        : clock
//   reset      : synchronous active-high, clears every register
//   we_i       : write enable
//   wa_i/wd_i  : write address / data
//   ra1_i/rd1_o: read port 1 address / data
//   ra2_i/rd2_o: read port 2 address / data
// -----------------------------------------------------------------------------
module regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i,
   input  logic [4:0]  ra1_i,
   output logic [31:0] rd1_o,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd2_o
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (wa_i != 5'd0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
   assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/riscv_32i.sv
// -----------------------------------------------------------------------------
// riscv_32i -- single-cycle RV32I core. Every rising clock edge retires one
// instruction. Instruction and data memories are external, word-wide and
// combinational on read; sub-word stores are done as read-merge-write of the
// whole word within the same cycle.
//
// Parameter:
//   RESET_PC  : PC loaded by reset
// Ports:
//   clk       : clock
//   reset     : synchronous active-high reset
//   pc        : byte address of the current instruction
//   instr     : instruction word at pc (combinational)
//   memwrite  : data-word write enable, sampled by memory at posedge clk
//   aluout    : ALU result, also the data byte address
//   writedata : full word written at aluout[31:2] when memwrite=1
//   readdata  : word at aluout[31:2] (combinational)
//   dbg       : per-instruction trace (only when DBG_EN is defined)
//
// Build option: define DBG_EN to add the dbg trace port.
// FENCE, ECALL, EBREAK and any undefined encoding execute as NOPs.
// -----------------------------------------------------------------------------
module riscv_32i
   import dbg_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   input  logic [31:0] instr,
   output logic        memwrite,
   output logic [31:0] aluout,
   output logic [31:0] writedata,
   input  logic [31:0] readdata
`ifdef DBG_EN
   ,
   output mem_debug    dbg
`endif
);

   // ------------------------------------------------------------------ fields
   logic [6:0] opcode;
   logic [4:0] rd;
   logic [2:0] f3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [6:0] f7;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign f7     = instr[31:25];

   // -------------------------------------------------------------- immediates
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // ----------------------------------------------------------------- PC reg
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;
   assign pc       = pc_q;

   // ---------------------------------------------------------------- decode
   logic       regwrite_dec;
   logic       memwrite_dec;
   logic       is_jump;
   logic       is_jalr;
   logic       is_branch;
   logic       b_from_imm;
   logic       legal;
   logic [31:0] imm;
   alu_a_sel_e a_sel;
   alu_ctrl_e  alu_ctrl;
   wb_sel_e    wb_sel;

   always_comb begin
      regwrite_dec = 1'b0;
      memwrite_dec = 1'b0;
      is_jump      = 1'b0;
      is_jalr      = 1'b0;
      is_branch    = 1'b0;
      b_from_imm   = 1'b1;
      legal        = 1'b0;
      imm          = imm_i;
      a_sel        = A_RS1;
      alu_ctrl     = ALU_ADD;
      wb_sel       = WB_ALU;
      case (opcode)
         LUI: begin
            regwrite_dec = 1'b1;
            a_sel        = A_ZERO;
            imm          = imm_u;
         end
         AUIPC: begin
            regwrite_dec = 1'b1;
            a_sel        = A_PC;
            imm          = imm_u;
         end
         JAL: begin
            // ALU forms the target pc+imm; rd gets the link address.
            regwrite_dec = 1'b1;
            a_sel        = A_PC;
            imm          = imm_j;
            wb_sel       = WB_PC4;
            is_jump      = 1'b1;
         end
         JALR: begin
            if (f3 == 3'd0) begin
               regwrite_dec = 1'b1;
               wb_sel       = WB_PC4;
               is_jalr      = 1'b1;
            end
         end
         BRANCH: begin
            // funct3 2 and 3 are unassigned branch encodings.
            if (f3 != 3'd2 && f3 != 3'd3) begin
               is_branch = 1'b1;
               a_sel     = A_PC;
               imm       = imm_b;
            end
         end
         LOAD: begin
            if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
               regwrite_dec = 1'b1;
               wb_sel       = WB_MEM;
            end
         end
         STORE: begin
            imm = imm_s;
            if (f3 inside {3'd0, 3'd1, 3'd2}) begin
               memwrite_dec = 1'b1;
            end
         end
         OP_IMM: begin
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 legal = 1'b1;
            alu_ctrl     = alu_decode(f3, (f3 == 3'd5) && instr[30]);
            regwrite_dec = legal;
         end
         OP: begin
            b_from_imm   = 1'b0;
            legal        = (f7 == 7'h00) ||
                           ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            alu_ctrl     = alu_decode(f3, instr[30]);
            regwrite_dec = legal;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- regfile
   logic [31:0] rs1_data, rs2_data;
   logic [31:0] rd_wdata;
   logic        regwrite;

   // A reset cycle never commits architectural state.
   assign regwrite = regwrite_dec & ~reset;
   assign memwrite = memwrite_dec & ~reset;

   regfile u_regfile (
      .clk   (clk),
      .reset (reset),
      .we_i  (regwrite),
      .wa_i  (rd),
      .wd_i  (rd_wdata),
      .ra1_i (rs1),
      .rd1_o (rs1_data),
      .ra2_i (rs2),
      .rd2_o (rs2_data)
   );

   // ------------------------------------------------------------------ ALU
   logic [31:0] alu_a, alu_b, alu_y;
   logic [4:0]  shamt;

   always_comb begin
      case (a_sel)
         A_PC:    alu_a = pc_q;
         A_ZERO:  alu_a = 32'd0;
         default: alu_a = rs1_data;
      endcase
   end

   assign alu_b = b_from_imm ? imm : rs2_data;
   assign shamt = alu_b[4:0];

   always_comb begin
      case (alu_ctrl)
         ALU_SUB:  alu_y = alu_a - alu_b;
         ALU_SLL:  alu_y = alu_a << shamt;
         ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
         ALU_XOR:  alu_y = alu_a ^ alu_b;
         ALU_SRL:  alu_y = alu_a >> shamt;
         ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> shamt);
         ALU_OR:   alu_y = alu_a | alu_b;
         ALU_AND:  alu_y = alu_a & alu_b;
         default:  alu_y = alu_a + alu_b;
      endcase
   end

   assign aluout = alu_y;

   // ------------------------------------------------------- branch compare
   logic br_cond;

   always_comb begin
      case (f3)
         3'd0:    br_cond = (rs1_data == rs2_data);
         3'd1:    br_cond = (rs1_data != rs2_data);
         3'd4:    br_cond = ($signed(rs1_data) <  $signed(rs2_data));
         3'd5:    br_cond = ($signed(rs1_data) >= $signed(rs2_data));
         3'd6:    br_cond = (rs1_data <  rs2_data);
         3'd7:    br_cond = (rs1_data >= rs2_data);
         default: br_cond = 1'b0;
      endcase
   end

   // ------------------------------------------------------------- next PC
   // For JAL and branches the ALU already holds pc+imm; for JALR it holds
   // rs1+imm, whose bit 0 is dropped. No alignment checking is done.
   always_comb begin
      if (is_jalr)
         pc_d = {alu_y[31:1], 1'b0};
      else if (is_jump || (is_branch && br_cond))
         pc_d = alu_y;
      else
         pc_d = pc_plus4;
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   // ------------------------------------------------------ load alignment
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign ld_byte = readdata[{alu_y[1:0], 3'b000} +: 8];
   assign ld_half = alu_y[1] ? readdata[31:16] : readdata[15:0];

   always_comb begin
      case (f3)
         3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
         3'd4:    ld_data = {24'd0, ld_byte};
         3'd5:    ld_data = {16'd0, ld_half};
         default: ld_data = readdata;
      endcase
   end

   // ---------------------------------------------------- store read-merge
   // Sub-word stores rewrite the whole word: untouched lanes come from
   // readdata (same address), addressed lanes from rs2. SH uses the natural
   // half selected by aluout[1]; address bit 0 is ignored for SH.
   logic [31:0] st_merge;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       lane_en;
         logic [7:0] lane_src;

         assign lane_en  = ((f3 == 3'd0) && (alu_y[1:0] == LANE)) ||
                           ((f3 == 3'd1) && (alu_y[1] == LANE[1]));
         assign lane_src = (f3 == 3'd0) ? rs2_data[7:0]
                                        : rs2_data[8*(gi % 2) +: 8];
         assign st_merge[8*gi +: 8] = lane_en ? lane_src : readdata[8*gi +: 8];
      end
   endgenerate

   assign writedata = (f3 == 3'd2) ? rs2_data : st_merge;

   // ---------------------------------------------------------- write-back
   always_comb begin
      case (wb_sel)
         WB_MEM:  rd_wdata = ld_data;
         WB_PC4:  rd_wdata = pc_plus4;
         default: rd_wdata = alu_y;
      endcase
   end

`ifdef DBG_EN
   assign dbg = '{pc:        pc_q,
                  instr:     instr,
                  regwrite:  regwrite,
                  rd:        rd,
                  rd_wdata:  rd_wdata,
                  memwrite:  memwrite,
                  aluout:    alu_y,
                  writedata: writedata};
`endif

endmodule

// File: tb/tb_riscv_32i.sv
// -----------------------------------------------------------------------------
// tb_riscv_32i -- directed self-checking bench for riscv_32i.
// Provides combinational instruction and data memories (64 words each).
// Register contents are observed through ports by executing "addi x0,xN,0",
// whose aluout equals xN.
// -----------------------------------------------------------------------------
module tb_riscv_32i;
`ifdef DBG_EN
   import dbg_pkg::*;
`endif

   localparam logic [6:0] O_OPI  = 7'h13;
   localparam logic [6:0] O_LD   = 7'h03;
   localparam logic [6:0] O_LUI  = 7'h37;
   localparam logic [6:0] O_AUI  = 7'h17;
   localparam logic [6:0] O_JALR = 7'h67;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc, instr, aluout, writedata, readdata;
   logic        memwrite;
   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   int          n_vec = 0;
   int          n_err = 0;

`ifdef DBG_EN
   mem_debug dbg;
`endif

   always #5 clk = ~clk;

   assign instr    = imem[pc[7:2]];
   assign readdata = dmem[aluout[7:2]];

   always @(posedge clk) begin
      if (memwrite) dmem[aluout[7:2]] <= writedata;
   end

   riscv_32i #(.RESET_PC(32'h0000_0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .instr     (instr),
      .memwrite  (memwrite),
      .aluout    (aluout),
      .writedata (writedata),
      .readdata  (readdata)
`ifdef DBG_EN
      ,
      .dbg       (dbg)
`endif
   );

   // ----------------------------------------------------------- encoders
   function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   function automatic logic [31:0] u_t(input logic [19:0] imm20, input logic [4:0] rd,
                                       input logic [6:0] op);
      return {imm20, rd, op};
   endfunction

   // ------------------------------------------------------------ helpers
   task automatic clear_mem();
      for (int i = 0; i < 64; i++) begin
         imem[i] = 32'h0000_0013;
         dmem[i] = 32'd0;
      end
   endtask

   // Called at a negedge; returns at the negedge where pc=RESET_PC executes.
   task automatic reset_core();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      $display("  pc=%h instr=%h aluout=%h memwrite=%0b writedata=%h",
               pc, instr, aluout, memwrite, writedata);
   endtask

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      clear_mem();
      imem[0] = s_t(32'd0, 5'd0, 5'd0, 3'd2);          // sw x0,0(x0)
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      n_vec++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL reset_memwrite: got %b want 0", memwrite); end
      reset = 1'b0;
      #1;
      n_vec++; if (memwrite !== 1'b1) begin n_err++; $display("FAIL first_fetch_store: memwrite got %b want 1", memwrite); end
      step();
      n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL first_fetch_pc: got %h want %h", pc, 32'h4); end
   endtask

   task automatic test_add();
      clear_mem();
      imem[0] = i_t(32'd5, 5'd0, 3'd0, 5'd1, O_OPI);      // addi x1,x0,5
      imem[1] = i_t(-32'sd3, 5'd0, 3'd0, 5'd2, O_OPI);    // addi x2,x0,-3
      imem[2] = r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);       // add x3,x1,x2
      imem[3] = i_t(32'd0, 5'd3, 3'd0, 5'd0, O_OPI);      // addi x0,x3,0
      reset_core();
      n_vec++; if (aluout !== 32'd5) begin n_err++; $display("FAIL add_addi5: got %h want %h", aluout, 32'd5); end
      step();
      n_vec++; if (aluout !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL add_addim3: got %h want %h", aluout, 32'hFFFF_FFFD); end
      step();
      n_vec++; if (aluout !== 32'd2) begin n_err++; $display("FAIL add_sum: got %h want %h", aluout, 32'd2); end
      step();
      n_vec++; if (pc !== 32'd12) begin n_err++; $display("FAIL add_pc: got %h want %h", pc, 32'd12); end
      n_vec++; if (aluout !== 32'd2) begin n_err++; $display("FAIL add_x3: got %h want %h", aluout, 32'd2); end
   endtask

   task automatic test_store_load();
      clear_mem();
      imem[0] = u_t(20'h12345, 5'd1, O_LUI);              // lui x1,0x12345
      imem[1] = i_t(32'h678, 5'd1, 3'd0, 5'd1, O_OPI);    // addi x1,x1,0x678
      imem[2] = s_t(32'd64, 5'd1, 5'd0, 3'd2);            // sw x1,64(x0)
      imem[3] = i_t(32'd64, 5'd0, 3'd2, 5'd2, O_LD);      // lw x2,64(x0)
      imem[4] = i_t(32'd0, 5'd2, 3'd0, 5'd0, O_OPI);      // addi x0,x2,0
      reset_core();
      n_vec++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL sl_lui_mw: got %b want 0", memwrite); end
      step();
      n_vec++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL sl_addi_mw: got %b want 0", memwrite); end
      step();
      n_vec++; if (memwrite !== 1'b1) begin n_err++; $display("FAIL sl_sw_mw: got %b want 1", memwrite); end
      n_vec++; if (aluout !== 32'd64) begin n_err++; $display("FAIL sl_sw_addr: got %h want %h", aluout, 32'd64); end
      n_vec++; if (writedata !== 32'h1234_5678) begin n_err++; $display("FAIL sl_sw_data: got %h want %h", writedata, 32'h1234_5678); end
      step();
      n_vec++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL sl_lw_mw: got %b want 0", memwrite); end
      n_vec++; if (dmem[16] !== 32'h1234_5678) begin n_err++; $display("FAIL sl_mem: got %h want %h", dmem[16], 32'h1234_5678); end
      step();
      n_vec++; if (aluout !== 32'h1234_5678) begin n_err++; $display("FAIL sl_x2: got %h want %h", aluout, 32'h1234_5678); end
   endtask

   task automatic test_byte_half();
      clear_mem();
      dmem[16] = 32'h1234_5678;
      imem[0]  = i_t(32'hAB, 5'd0, 3'd0, 5'd5, O_OPI);    // addi x5,x0,0xAB
      imem[1]  = s_t(32'd65, 5'd5, 5'd0, 3'd0);           // sb x5,65(x0)
      imem[2]  = i_t(32'd65, 5'd0, 3'd0, 5'd6, O_LD);     // lb x6,65(x0)
      imem[3]  = i_t(32'd65, 5'd0, 3'd4, 5'd7, O_LD);     // lbu x7,65(x0)
      imem[4]  = i_t(32'd0, 5'd6, 3'd0, 5'd0, O_OPI);     // addi x0,x6,0
      imem[5]  = i_t(32'd0, 5'd7, 3'd0, 5'd0, O_OPI);     // addi x0,x7,0
      imem[6]  = s_t(32'd66, 5'd5, 5'd0, 3'd1);           // sh x5,66(x0)
      imem[7]  = i_t(32'd64, 5'd0, 3'd1, 5'd8, O_LD);     // lh x8,64(x0)
      imem[8]  = i_t(32'd66, 5'd0, 3'd5, 5'd9, O_LD);     // lhu x9,66(x0)
      imem[9]  = i_t(32'd0, 5'd8, 3'd0, 5'd0, O_OPI);     // addi x0,x8,0
      imem[10] = i_t(32'd0, 5'd9, 3'd0, 5'd0, O_OPI);     // addi x0,x9,0
      reset_core();
      step();
      n_vec++; if (memwrite !== 1'b1) begin n_err++; $display("FAIL sb_mw: got %b want 1", memwrite); end
      n_vec++; if (writedata !== 32'h1234_AB78) begin n_err++; $display("FAIL sb_merge: got %h want %h", writedata, 32'h1234_AB78); end
      step();
      n_vec++; if (dmem[16] !== 32'h1234_AB78) begin n_err++; $display("FAIL sb_mem: got %h want %h", dmem[16], 32'h1234_AB78); end
      step();
      step();
      n_vec++; if (aluout !== 32'hFFFF_FFAB) begin n_err++; $display("FAIL lb_sext: got %h want %h", aluout, 32'hFFFF_FFAB); end
      step();
      n_vec++; if (aluout !== 32'h0000_00AB) begin n_err++; $display("FAIL lbu_zext: got %h want %h", aluout, 32'h0000_00AB); end
      step();
      n_vec++; if (writedata !== 32'h00AB_AB78) begin n_err++; $display("FAIL sh_merge: got %h want %h", writedata, 32'h00AB_AB78); end
      step();
      step();
      step();
      n_vec++; if (aluout !== 32'hFFFF_AB78) begin n_err++; $display("FAIL lh_sext: got %h want %h", aluout, 32'hFFFF_AB78); end
      step();
      n_vec++; if (aluout !== 32'h0000_00AB) begin n_err++; $display("FAIL lhu_upper: got %h want %h", aluout, 32'h0000_00AB); end
   endtask

   task automatic test_branch_jump();
      clear_mem();
      imem[0]  = i_t(-32'sd1, 5'd0, 3'd0, 5'd1, O_OPI);   // 0x00 addi x1,x0,-1
      imem[1]  = b_t(32'd8, 5'd0, 5'd0, 3'd1);            // 0x04 bne x0,x0,+8
      imem[2]  = b_t(32'd8, 5'd0, 5'd1, 3'd4);            // 0x08 blt x1,x0,+8
      imem[4]  = b_t(32'd8, 5'd0, 5'd1, 3'd6);            // 0x10 bltu x1,x0,+8
      imem[5]  = j_t(32'd12, 5'd0);                       // 0x14 jal x0,+12
      imem[8]  = j_t(32'd16, 5'd1);                       // 0x20 jal x1,+16
      imem[12] = i_t(32'd3, 5'd1, 3'd0, 5'd0, O_JALR);    // 0x30 jalr x0,3(x1)
      imem[9]  = i_t(32'd0, 5'd1, 3'd0, 5'd0, O_OPI);     // 0x24/0x26 addi x0,x1,0
      reset_core();
      step();
      n_vec++; if (pc !== 32'h04) begin n_err++; $display("FAIL br_seq: got %h want %h", pc, 32'h04); end
      step();
      n_vec++; if (pc !== 32'h08) begin n_err++; $display("FAIL bne_not_taken: got %h want %h", pc, 32'h08); end
      step();
      n_vec++; if (pc !== 32'h10) begin n_err++; $display("FAIL blt_taken: got %h want %h", pc, 32'h10); end
      step();
      n_vec++; if (pc !== 32'h14) begin n_err++; $display("FAIL bltu_not_taken: got %h want %h", pc, 32'h14); end
      step();
      n_vec++; if (pc !== 32'h20) begin n_err++; $display("FAIL jal_fwd: got %h want %h", pc, 32'h20); end
      step();
      n_vec++; if (pc !== 32'h30) begin n_err++; $display("FAIL jal_link_pc: got %h want %h", pc, 32'h30); end
      step();
      n_vec++; if (pc !== 32'h26) begin n_err++; $display("FAIL jalr_pc: got %h want %h", pc, 32'h26); end
      n_vec++; if (aluout !== 32'h24) begin n_err++; $display("FAIL jal_link_x1: got %h want %h", aluout, 32'h24); end
      step();
      n_vec++; if (pc !== 32'h2A) begin n_err++; $display("FAIL misaligned_seq: got %h want %h", pc, 32'h2A); end
   endtask

   task automatic test_x0_reset();
      clear_mem();
      dmem[16] = 32'hDEAD_BEEF;
      imem[0] = i_t(32'd7, 5'd0, 3'd0, 5'd0, O_OPI);      // addi x0,x0,7
      imem[1] = i_t(32'd0, 5'd0, 3'd0, 5'd10, O_OPI);     // addi x10,x0,0
      imem[2] = i_t(32'h55, 5'd0, 3'd0, 5'd1, O_OPI);     // addi x1,x0,0x55
      imem[3] = s_t(32'd64, 5'd1, 5'd0, 3'd2);            // sw x1,64(x0)
      reset_core();
      n_vec++; if (aluout !== 32'd7) begin n_err++; $display("FAIL x0_addi_alu: got %h want %h", aluout, 32'd7); end
      step();
      n_vec++; if (aluout !== 32'd0) begin n_err++; $display("FAIL x0_reads_zero: got %h want %h", aluout, 32'd0); end
      step();
      n_vec++; if (aluout !== 32'h55) begin n_err++; $display("FAIL x0_set_x1: got %h want %h", aluout, 32'h55); end
      step();
      n_vec++; if (memwrite !== 1'b1) begin n_err++; $display("FAIL rst_pre_store: got %b want 1", memwrite); end
      reset = 1'b1;
      imem[0] = i_t(32'd0, 5'd1, 3'd0, 5'd0, O_OPI);      // addi x0,x1,0
      #1;
      n_vec++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL rst_store_blocked: got %b want 0", memwrite); end
      @(negedge clk);
      n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_mid_pc: got %h want %h", pc, 32'h0); end
      n_vec++; if (dmem[16] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rst_no_write: got %h want %h", dmem[16], 32'hDEAD_BEEF); end
      reset = 1'b0;
      #1;
      n_vec++; if (aluout !== 32'd0) begin n_err++; $display("FAIL rst_clears_x1: got %h want %h", aluout, 32'd0); end
   endtask

   task automatic test_shift_compare();
      clear_mem();
      imem[0] = u_t(20'h80000, 5'd1, O_LUI);              // lui x1,0x80000
      imem[1] = i_t(32'h404, 5'd1, 3'd5, 5'd2, O_OPI);    // srai x2,x1,4
      imem[2] = i_t(32'h004, 5'd1, 3'd5, 5'd3, O_OPI);    // srli x3,x1,4
      imem[3] = r_t(7'h00, 5'd0, 5'd1, 3'd2, 5'd4);       // slt x4,x1,x0
      imem[4] = r_t(7'h00, 5'd0, 5'd1, 3'd3, 5'd5);       // sltu x5,x1,x0
      imem[5] = i_t(32'd36, 5'd0, 3'd0, 5'd6, O_OPI);     // addi x6,x0,36
      imem[6] = r_t(7'h20, 5'd6, 5'd1, 3'd5, 5'd7);       // sra x7,x1,x6 (shamt 4)
      imem[7] = r_t(7'h20, 5'd6, 5'd0, 3'd0, 5'd8);       // sub x8,x0,x6
      imem[8] = r_t(7'h00, 5'd6, 5'd6, 3'd1, 5'd9);       // sll x9,x6,x6
      reset_core();
      n_vec++; if (aluout !== 32'h8000_0000) begin n_err++; $display("FAIL lui: got %h want %h", aluout, 32'h8000_0000); end
      step();
      n_vec++; if (aluout !== 32'hF800_0000) begin n_err++; $display("FAIL srai: got %h want %h", aluout, 32'hF800_0000); end
      step();
      n_vec++; if (aluout !== 32'h0800_0000) begin n_err++; $display("FAIL srli: got %h want %h", aluout, 32'h0800_0000); end
      step();
      n_vec++; if (aluout !== 32'd1) begin n_err++; $display("FAIL slt: got %h want %h", aluout, 32'd1); end
      step();
      n_vec++; if (aluout !== 32'd0) begin n_err++; $display("FAIL sltu: got %h want %h", aluout, 32'd0); end
      step();
      step();
      n_vec++; if (aluout !== 32'hF800_0000) begin n_err++; $display("FAIL sra_5bit: got %h want %h", aluout, 32'hF800_0000); end
      step();
      n_vec++; if (aluout !== 32'hFFFF_FFDC) begin n_err++; $display("FAIL sub: got %h want %h", aluout, 32'hFFFF_FFDC); end
      step();
      n_vec++; if (aluout !== 32'h0000_0240) begin n_err++; $display("FAIL sll_5bit: got %h want %h", aluout, 32'h0000_0240); end
   endtask

   task automatic test_back_to_back();
      clear_mem();
      imem[0] = i_t(32'd1, 5'd0, 3'd0, 5'd1, O_OPI);      // addi x1,x0,1
      imem[1] = i_t(32'd1, 5'd1, 3'd0, 5'd1, O_OPI);      // addi x1,x1,1
      imem[2] = i_t(32'd1, 5'd1, 3'd0, 5'd1, O_OPI);      // addi x1,x1,1
      imem[3] = i_t(32'd0, 5'd1, 3'd0, 5'd0, O_OPI);      // addi x0,x1,0
      imem[4] = u_t(20'h00001, 5'd2, O_AUI);              // 0x10 auipc x2,1
      imem[5] = 32'hFFFF_FFFF;                            // undefined
      imem[6] = 32'h0000_0073;                            // ecall
      imem[7] = s_t(32'd0, 5'd1, 5'd0, 3'd3);             // store funct3=3 (undefined)
      reset_core();
      step();
      n_vec++; if (aluout !== 32'd2) begin n_err++; $display("FAIL b2b_1: got %h want %h", aluout, 32'd2); end
      step();
      n_vec++; if (aluout !== 32'd3) begin n_err++; $display("FAIL b2b_2: got %h want %h", aluout, 32'd3); end
      step();
      n_vec++; if (aluout !== 32'd3) begin n_err++; $display("FAIL b2b_x1: got %h want %h", aluout, 32'd3); end
      step();
      n_vec++; if (aluout !== 32'h0000_1010) begin n_err++; $display("FAIL auipc: got %h want %h", aluout, 32'h0000_1010); end
      step();
      n_vec++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL undef_mw: got %b want 0", memwrite); end
      step();
      n_vec++; if (pc !== 32'h18) begin n_err++; $display("FAIL undef_pc: got %h want %h", pc, 32'h18); end
      step();
      n_vec++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL bad_store_mw: got %b want 0", memwrite); end
      step();
      n_vec++; if (pc !== 32'h20) begin n_err++; $display("FAIL nop_pc: got %h want %h", pc, 32'h20); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_store_load();
      test_byte_half();
      test_branch_jump();
      test_x0_reset();
      test_shift_compare();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
